// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller and the lights decoder.
// State encoding is fixed because the seven-segment decoder consumes it directly.
package elevator_pkg;

  localparam int FLOOR_W_DEF    = 3;
  localparam int NUM_FLOORS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_DOOR = 2'b11
  } state_t;

  // Width of a down-counter that must hold values up to max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: any latched call above, below or at the given floor.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  above,
  output logic                  below,
  output logic                  here
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor)  above = above | pending[i];
      if (FLOOR_W'(i) < floor)  below = below | pending[i];
      if (FLOOR_W'(i) == floor) here  = here  | pending[i];
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car elevator controller: latches calls, moves the car with a SCAN policy,
// and times floor-to-floor travel and door dwell with one shared down-counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | parked, no calls; serves own floor first, then up, then down
//   ST_UP   | travelling up, counter times one floor; stops at called floors
//   ST_DOWN | travelling down, same as ST_UP in the other direction
//   ST_DOOR | door open, counter times dwell; hold/own-floor call restarts it
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int FLOOR_W       = FLOOR_W_DEF,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  door_hold,
  input  logic                  estop,
  output logic [FLOOR_W-1:0]    floornum,
  output state_t                state,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open
);

  localparam int                 CNT_W       = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  logic [CNT_W-1:0]      cnt;
  logic                  dir_down;
  logic                  above, below, here;
  logic                  above_next, below_next, here_next;
  logic                  moving, tc, at_end, req_here, stop;
  logic                  ahead_next, behind_next, go_up, go_down;
  logic [FLOOR_W-1:0]    next_floor;
  logic [NUM_FLOORS-1:0] pending_next;

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
    .pending (pending),
    .floor   (floornum),
    .above   (above),
    .below   (below),
    .here    (here)
  );

  // Looks one floor ahead so the arrival decision is made on the edge the car moves.
  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_next (
    .pending (pending),
    .floor   (next_floor),
    .above   (above_next),
    .below   (below_next),
    .here    (here_next)
  );

  assign moving      = (state == ST_UP) || (state == ST_DOWN);
  assign tc          = (cnt == '0);
  assign next_floor  = (state == ST_DOWN) ? floornum - 1'b1 : floornum + 1'b1;
  assign at_end      = ((state == ST_UP) && (floornum == TOP_FLOOR)) ||
                       ((state == ST_DOWN) && (floornum == '0));
  assign req_here    = req[floornum];
  assign stop        = here_next | req[next_floor];
  assign ahead_next  = (state == ST_DOWN) ? below_next : above_next;
  assign behind_next = (state == ST_DOWN) ? above_next : below_next;

  // Door expiry: keep the previous direction when it still has work.
  assign go_up   = dir_down ? (above && !below) : above;
  assign go_down = dir_down ? below : (below && !above);

  always_comb begin
    pending_next = pending | req;
    if (!estop) begin
      if (!moving)
        pending_next[floornum] = 1'b0;
      else if (tc && !at_end && stop)
        pending_next[next_floor] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      floornum  <= '0;
      pending   <= '0;
      door_open <= 1'b0;
      cnt       <= '0;
      dir_down  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (!estop) begin
        unique case (state)
          ST_IDLE: begin
            if (here || req_here) begin
              state     <= ST_DOOR;
              door_open <= 1'b1;
              cnt       <= DOOR_LOAD;
              dir_down  <= 1'b0;
            end else if (above) begin
              state <= ST_UP;
              cnt   <= TRAVEL_LOAD;
            end else if (below) begin
              state <= ST_DOWN;
              cnt   <= TRAVEL_LOAD;
            end
          end
          ST_UP, ST_DOWN: begin
            if (!tc) begin
              cnt <= cnt - 1'b1;
            end else if (at_end) begin
              state <= ST_IDLE;
            end else begin
              floornum <= next_floor;
              if (stop) begin
                state     <= ST_DOOR;
                door_open <= 1'b1;
                cnt       <= DOOR_LOAD;
                dir_down  <= (state == ST_DOWN);
              end else if (ahead_next) begin
                cnt <= TRAVEL_LOAD;
              end else if (behind_next) begin
                state <= (state == ST_UP) ? ST_DOWN : ST_UP;
                cnt   <= TRAVEL_LOAD;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_DOOR: begin
            if (door_hold || req_here) begin
              cnt <= DOOR_LOAD;
            end else if (!tc) begin
              cnt <= cnt - 1'b1;
            end else begin
              door_open <= 1'b0;
              if (go_up) begin
                state <= ST_UP;
                cnt   <= TRAVEL_LOAD;
              end else if (go_down) begin
                state <= ST_DOWN;
                cnt   <= TRAVEL_LOAD;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state     <= ST_IDLE;
            door_open <= 1'b0;
          end
        endcase
      end
    end
  end

  // SCAN only moves toward a pending call, so the car never runs off either end.
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(moving && tc && at_end && !estop));
  a_floor_range: assert property (@(posedge clk) disable iff (!rst_n)
    floornum <= TOP_FLOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle stamps;
// a negedge monitor pops one entry every time any DUT output changes.
module tb_elevator_scheduler;
  import elevator_pkg::*;

  typedef struct {
    int          at;
    logic [2:0]  fl;
    logic [1:0]  st;
    logic [7:0]  pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       door_hold = 1'b0;
  logic       estop = 1'b0;
  logic [2:0] floornum;
  state_t     st;
  logic [7:0] pending;
  logic       door_open;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   evt_idx = 0;
  exp_t exp_q[$];

  logic [2:0] prev_fl;
  logic [1:0] prev_st;
  logic [7:0] prev_pend;
  logic       prev_door;

  elevator_scheduler #(
    .NUM_FLOORS    (8),
    .FLOOR_W       (3),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .door_hold (door_hold),
    .estop     (estop),
    .floornum  (floornum),
    .state     (st),
    .pending   (pending),
    .door_open (door_open)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_fl   = '0;
      prev_st   = '0;
      prev_pend = '0;
      prev_door = 1'b0;
    end else if ({floornum, 2'(st), pending, door_open} !=
                 {prev_fl, prev_st, prev_pend, prev_door}) begin
      prev_fl   = floornum;
      prev_st   = 2'(st);
      prev_pend = pending;
      prev_door = door_open;
      evt_idx++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event_%0d: got cyc=%0d fl=%0d st=%0d pend=%h door=%0d, required no change",
                 evt_idx, cyc, floornum, st, pending, door_open);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.at || floornum !== e.fl || 2'(st) !== e.st || pending !== e.pend ||
            door_open !== (e.st == 2'b11)) begin
          errors++;
          $display("FAIL event_%0d: got cyc=%0d fl=%0d st=%0d pend=%h door=%0d, required cyc=%0d fl=%0d st=%0d pend=%h door=%0d",
                   evt_idx, cyc, floornum, st, pending, door_open,
                   e.at, e.fl, e.st, e.pend, (e.st == 2'b11));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse(input logic [7:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic ex(input int at, input int fl, input int st_v, input int p);
    exp_t e;
    e.at   = at;
    e.fl   = 3'(fl);
    e.st   = 2'(st_v);
    e.pend = 8'(p);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d outstanding events required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  initial begin
    int c;
    repeat (3) tick();
    chk("rst_floor", 32'(floornum), 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset while travelling up past floor 3.
    c = cyc;
    ex(c+1, 0, 0, 'h40); ex(c+2, 0, 1, 'h40); ex(c+6, 1, 1, 'h40);
    ex(c+10, 2, 1, 'h40); ex(c+14, 3, 1, 'h40);
    pulse(8'h40);
    goto(c+15);
    rst_n = 1'b0;
    #1;
    chk("midrst_floor", 32'(floornum), 32'd0);
    chk("midrst_state", 32'(st), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_door", 32'(door_open), 32'd0);
    tick();
    rst_n = 1'b1;
    drain("reset_mid_up");

    // Floor 0 to 5, dwell, idle.
    c = cyc;
    ex(c+1, 0, 0, 'h20); ex(c+2, 0, 1, 'h20); ex(c+6, 1, 1, 'h20);
    ex(c+10, 2, 1, 'h20); ex(c+14, 3, 1, 'h20); ex(c+18, 4, 1, 'h20);
    ex(c+22, 5, 3, 'h00); ex(c+28, 5, 0, 'h00);
    pulse(8'h20);
    drain("run_0_to_5");

    // Down to floor 2.
    c = cyc;
    ex(c+1, 5, 0, 'h04); ex(c+2, 5, 2, 'h04); ex(c+6, 4, 2, 'h04);
    ex(c+10, 3, 2, 'h04); ex(c+14, 2, 3, 'h00); ex(c+20, 2, 0, 'h00);
    pulse(8'h04);
    drain("run_5_to_2");

    // SCAN: up from 2 toward 6 with calls at 1 and 4.
    c = cyc;
    ex(c+1, 2, 0, 'h40); ex(c+2, 2, 1, 'h40); ex(c+3, 2, 1, 'h52);
    ex(c+6, 3, 1, 'h52); ex(c+10, 4, 3, 'h42); ex(c+16, 4, 1, 'h42);
    ex(c+20, 5, 1, 'h42); ex(c+24, 6, 3, 'h02); ex(c+30, 6, 2, 'h02);
    ex(c+34, 5, 2, 'h02); ex(c+38, 4, 2, 'h02); ex(c+42, 3, 2, 'h02);
    ex(c+46, 2, 2, 'h02); ex(c+50, 1, 3, 'h00); ex(c+56, 1, 0, 'h00);
    pulse(8'h40);
    goto(c+2);
    pulse(8'h12);
    drain("scan_2_4_6_1");

    // Emergency stop for 10 clocks mid-travel; a call still latches.
    c = cyc;
    ex(c+1, 1, 0, 'h08); ex(c+2, 1, 1, 'h08); ex(c+5, 1, 1, 'h88);
    ex(c+16, 2, 1, 'h88); ex(c+20, 3, 3, 'h80); ex(c+26, 3, 1, 'h80);
    ex(c+30, 4, 1, 'h80); ex(c+34, 5, 1, 'h80); ex(c+38, 6, 1, 'h80);
    ex(c+42, 7, 3, 'h00); ex(c+48, 7, 0, 'h00);
    pulse(8'h08);
    goto(c+4);
    estop = 1'b1;
    pulse(8'h80);
    goto(c+14);
    estop = 1'b0;
    drain("estop");

    // Top floor: own call and floor-0 call together.
    c = cyc;
    ex(c+1, 7, 3, 'h01); ex(c+7, 7, 2, 'h01); ex(c+11, 6, 2, 'h01);
    ex(c+15, 5, 2, 'h01); ex(c+19, 4, 2, 'h01); ex(c+23, 3, 2, 'h01);
    ex(c+27, 2, 2, 'h01); ex(c+31, 1, 2, 'h01); ex(c+35, 0, 3, 'h00);
    ex(c+41, 0, 0, 'h00);
    pulse(8'h81);
    drain("top_then_bottom");

    // Up to floor 3.
    c = cyc;
    ex(c+1, 0, 0, 'h08); ex(c+2, 0, 1, 'h08); ex(c+6, 1, 1, 'h08);
    ex(c+10, 2, 1, 'h08); ex(c+14, 3, 3, 'h00); ex(c+20, 3, 0, 'h00);
    pulse(8'h08);
    drain("run_0_to_3");

    // Own-floor call held for 10 clocks keeps the door open, then 6 more.
    c = cyc;
    ex(c+1, 3, 3, 'h00); ex(c+16, 3, 0, 'h00);
    req = 8'h08;
    goto(c+10);
    req = '0;
    drain("held_call");

    // door_hold for 3 clocks restarts the dwell.
    c = cyc;
    ex(c+1, 3, 3, 'h00); ex(c+11, 3, 0, 'h00);
    pulse(8'h08);
    goto(c+2);
    door_hold = 1'b1;
    goto(c+5);
    door_hold = 1'b0;
    drain("door_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, required finish", $time);
    $fatal(1);
  end

endmodule
